// File: rtl/frogger_pkg.sv
// frogger_pkg: screen bounds, start position, lane rows, FSM states and hop helper
package frogger_pkg;
  localparam logic signed [10:0] L_MIN   = 11'sd0;
  localparam logic signed [10:0] L_MAX   = 11'sd610;
  localparam logic signed [10:0] B_MIN   = 11'sd70;
  localparam logic signed [10:0] B_MAX   = 11'sd470;
  localparam logic signed [10:0] START_L = 11'sd305;
  localparam logic signed [10:0] START_B = 11'sd470;
  localparam logic signed [10:0] ANIM_PX = 11'sd4;
  // Lane k bottom row sits at index k: 430, 350, 270, 190
  localparam logic [3:0][10:0] LANE_BOT = {11'd190, 11'd270, 11'd350, 11'd430};
  typedef enum logic [1:0] {S_IDLE, S_HOP, S_HIT, S_RESPAWN} state_t;
  // Advance cur by at most ANIM_PX toward tgt, landing exactly on tgt when close
  function automatic logic signed [10:0] step_toward(input logic signed [10:0] cur, input logic signed [10:0] tgt);
    logic signed [10:0] d;
    d = tgt - cur;
    return (d > ANIM_PX) ? cur + ANIM_PX : (d < -ANIM_PX) ? cur - ANIM_PX : tgt;
  endfunction
endpackage

// File: rtl/btn_edge.sv
// btn_edge: two-flop synchroniser with a one-cycle rising-edge pulse
module btn_edge (
  input  logic clk_in,
  input  logic reset_in,
  input  logic i_btn,
  output logic o_rise
);
  logic r_meta, r_sync, r_prev;
  // Shift the raw level through the synchroniser and keep the previous synced level
  always_ff @(posedge clk_in)
    if (reset_in) {r_meta, r_sync, r_prev} <= 3'b000;
    else {r_meta, r_sync, r_prev} <= {i_btn, r_meta, r_sync};
  assign o_rise = r_sync & ~r_prev;
endmodule

// File: rtl/frog_ctrl.sv
// frog_ctrl: frog position FSM with hop, collision and respawn (FROG_HOP_ANIM_EN animates hops)
module frog_ctrl
  import frogger_pkg::*;
#(
  parameter int STEP    = 40,
  parameter int FROG_SZ = 30,
  parameter int CAR_W   = 60
) (
  input  logic       clk_in,
  input  logic       reset_in,
  input  logic       tick_in,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       respawn_n_in,
  input  logic [9:0] car_x0,
  input  logic [9:0] car_x1,
  input  logic [9:0] car_x2,
  input  logic [9:0] car_x3,
  output logic [9:0] frogL,
  output logic [8:0] frogT,
  output logic [9:0] frogR,
  output logic [8:0] frogB,
  output logic       collision_o,
  output logic       hop_busy
);
  localparam logic signed [10:0] C_STEP = 11'(STEP);
  state_t r_state;
  logic [9:0] r_l, r_tl;
  logic [8:0] r_b, r_tb;
  logic r_col;
  logic w_up, w_dn, w_lf, w_rt, w_go, w_hit, w_done;
  logic signed [10:0] w_l, w_b, w_tl, w_tb, w_mv_up, w_mv_dn, w_mv_lf, w_mv_rt, w_go_l, w_go_b, w_nl, w_nb;
  logic [3:0][9:0] w_car;
  btn_edge u_up (.clk_in(clk_in), .reset_in(reset_in), .i_btn(btn_up),    .o_rise(w_up));
  btn_edge u_dn (.clk_in(clk_in), .reset_in(reset_in), .i_btn(btn_down),  .o_rise(w_dn));
  btn_edge u_lf (.clk_in(clk_in), .reset_in(reset_in), .i_btn(btn_left),  .o_rise(w_lf));
  btn_edge u_rt (.clk_in(clk_in), .reset_in(reset_in), .i_btn(btn_right), .o_rise(w_rt));
  assign w_car   = {car_x3, car_x2, car_x1, car_x0};
  assign w_l     = $signed({1'b0, r_l});
  assign w_b     = $signed({2'b0, r_b});
  assign w_tl    = $signed({1'b0, r_tl});
  assign w_tb    = $signed({2'b0, r_tb});
  assign w_mv_up = w_b - C_STEP;
  assign w_mv_dn = w_b + C_STEP;
  assign w_mv_lf = w_l - C_STEP;
  assign w_mv_rt = w_l + C_STEP;
  // Only the highest-priority edge is considered; if its move leaves the screen it is dropped
  assign w_go    = w_up ? (w_mv_up >= B_MIN) : w_dn ? (w_mv_dn <= B_MAX) :
                   w_lf ? (w_mv_lf >= L_MIN) : (w_rt && (w_mv_rt <= L_MAX));
  assign w_go_l  = (w_up | w_dn) ? w_l : w_lf ? w_mv_lf : w_mv_rt;
  assign w_go_b  = w_up ? w_mv_up : w_dn ? w_mv_dn : w_b;
`ifdef FROG_HOP_ANIM_EN
  assign w_nl    = step_toward(w_l, w_tl);
  assign w_nb    = step_toward(w_b, w_tb);
`else
  assign w_nl    = w_tl;
  assign w_nb    = w_tb;
`endif
  assign w_done  = (w_nl == w_tl) && (w_nb == w_tb);
  // Hit when the frog sits on a lane bottom row and its span overlaps that lane's car
  always_comb begin
    w_hit = 1'b0;
    for (int k = 0; k < 4; k++)
      w_hit = w_hit | (({2'b0, r_b} == LANE_BOT[k]) &&
                       ({1'b0, r_l} < {1'b0, w_car[k]} + 11'(CAR_W)) &&
                       ({1'b0, w_car[k]} < {1'b0, r_l} + 11'(FROG_SZ)));
  end
  // Movement FSM: respawn overrides everything except reset
  always_ff @(posedge clk_in)
    if (reset_in || !respawn_n_in) begin
      r_state <= reset_in ? S_IDLE : S_RESPAWN;
      r_l     <= 10'(START_L);
      r_b     <= 9'(START_B);
      r_tl    <= 10'(START_L);
      r_tb    <= 9'(START_B);
      r_col   <= 1'b0;
    end else
      case (r_state)
        S_IDLE:
          if (w_hit) begin
            r_state <= S_HIT;
            r_col   <= 1'b1;
          end else if (w_go) begin
            r_state <= S_HOP;
            r_tl    <= 10'(w_go_l);
            r_tb    <= 9'(w_go_b);
          end
        S_HOP:
          if (tick_in) begin
            r_l <= 10'(w_nl);
            r_b <= 9'(w_nb);
            if (w_done) r_state <= S_IDLE;
          end
        S_HIT: r_state <= S_HIT;
        default: r_state <= S_IDLE;
      endcase
  assign frogL       = r_l;
  assign frogB       = r_b;
  assign frogR       = r_l + 10'(FROG_SZ);
  assign frogT       = r_b - 9'(FROG_SZ);
  assign collision_o = r_col;
  assign hop_busy    = (r_state == S_HOP);
endmodule
